// File: rtl/issue_queue_flush_return_sequencer.sv
// Issue-queue flush return sequencer.
// After a recovery this block either holds the free list in reset for a fixed
// number of cycles (full recovery) or walks a captured flushed-entry bitmap and
// returns the flagged indices to the free list, RETURN_WIDTH per cycle
// (selective recovery). All outputs are decoded from registered state.
module issue_queue_flush_return_sequencer #(
  parameter int ENTRY_NUM         = 16,
  parameter int RETURN_WIDTH      = 2,
  parameter int FULL_RESET_CYCLES = 8,
  parameter int IDX_W             = $clog2(ENTRY_NUM)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          startFull,
  input  logic                          startPartial,
  input  logic [ENTRY_NUM-1:0]          flushVector,
  output logic                          freeListReset,
  output logic [RETURN_WIDTH-1:0]       pushValid,
  output logic [RETURN_WIDTH*IDX_W-1:0] pushIndex,
  output logic                          busy,
  output logic                          done
);

  localparam int CNT_W = $clog2(FULL_RESET_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FULL_RESET_CYCLES - 1);
  localparam logic [IDX_W-1:0] OFFSET_STEP = IDX_W'(RETURN_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FULL   = 2'd1,
    RETURN = 2'd2
  } SeqState;

  SeqState               state,     stateNext;
  logic [ENTRY_NUM-1:0]  remaining, remainingNext;
  logic [IDX_W-1:0]      offset,    offsetNext;
  logic [CNT_W-1:0]      cnt,       cntNext;
  logic                  doneReg,   doneNext;

  // Entries covered by the current return chunk, and what is left once they go.
  logic [ENTRY_NUM-1:0]  chunkMask;
  logic [ENTRY_NUM-1:0]  clearedRemaining;
  logic [ENTRY_NUM-1:0]  mergedRemaining;

  // State register; done is registered so it lands in the first IDLE cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      offset    <= '0;
      cnt       <= '0;
      doneReg   <= 1'b0;
    end else begin
      state     <= stateNext;
      remaining <= remainingNext;
      offset    <= offsetNext;
      cnt       <= cntNext;
      doneReg   <= doneNext;
    end
  end

  // Chunk mask for the ports active this cycle; offset is always a multiple of
  // RETURN_WIDTH, so a chunk never straddles the wrap point.
  always_comb begin
    chunkMask = '0;
    for (int i = 0; i < RETURN_WIDTH; i++) begin
      chunkMask[offset + IDX_W'(i)] = 1'b1;
    end
    clearedRemaining = remaining & ~chunkMask;
    mergedRemaining  = startPartial ? (clearedRemaining | flushVector) : clearedRemaining;
  end

  // Next-state logic; startFull wins over everything in every state.
  // NOTE: every variable gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    stateNext     = state;
    remainingNext = remaining;
    offsetNext    = offset;
    cntNext       = cnt;
    doneNext      = 1'b0;

    if (startFull) begin
      // Pending partial returns are dropped: the free-list reset restores all.
      stateNext     = FULL;
      cntNext       = '0;
      remainingNext = '0;
      offsetNext    = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (startPartial) begin
            if (flushVector != '0) begin
              remainingNext = flushVector;
              offsetNext    = '0;
              stateNext     = RETURN;
            end else begin
              // Nothing flushed: complete immediately without any push.
              doneNext = 1'b1;
            end
          end
        end

        FULL: begin
          // startPartial is ignored while the free list is held in reset.
          if (cnt == CNT_LAST) begin
            stateNext = IDLE;
            cntNext   = '0;
            doneNext  = 1'b1;
          end else begin
            cntNext = cnt + CNT_W'(1);
          end
        end

        RETURN: begin
          // Current chunk is pushed this cycle; a nested startPartial merges new
          // entries and the scan keeps going, relying on wrap-around to reach them.
          remainingNext = mergedRemaining;
          offsetNext    = offset + OFFSET_STEP;
          if (mergedRemaining == '0) begin
            stateNext = IDLE;
            doneNext  = 1'b1;
          end
        end

        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

  // Moore output decode from registered state only.
  always_comb begin
    busy          = (state != IDLE);
    freeListReset = (state == FULL);
    done          = doneReg;
    pushValid     = '0;
    pushIndex     = '0;
    if (state == RETURN) begin
      for (int i = 0; i < RETURN_WIDTH; i++) begin
        pushValid[i]               = remaining[offset + IDX_W'(i)];
        pushIndex[i*IDX_W +: IDX_W] = offset + IDX_W'(i);
      end
    end
  end

  // Structural sanity: completion is never reported while still busy, and
  // pushes only happen during the return scan.
  doneNotBusy: assert property (@(posedge clk) disable iff (!rst) done |-> !busy);
  pushOnlyInReturn: assert property (@(posedge clk) disable iff (!rst)
                                     (pushValid != '0) |-> (state == RETURN));

endmodule

// File: tb/tb_issue_queue_flush_return_sequencer.sv
// Self-checking bench for issue_queue_flush_return_sequencer: directed cases
// with hand-computed expectations, then random traffic against a behavioural
// model and a per-sequence return scoreboard.
module tb_issue_queue_flush_return_sequencer;

  localparam int EN  = 16;
  localparam int RW  = 2;
  localparam int FRC = 8;
  localparam int IW  = $clog2(EN);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            startFull = 1'b0;
  logic            startPartial = 1'b0;
  logic [EN-1:0]   flushVector = '0;
  logic            freeListReset;
  logic [RW-1:0]   pushValid;
  logic [RW*IW-1:0] pushIndex;
  logic            busy;
  logic            done;

  issue_queue_flush_return_sequencer #(
    .ENTRY_NUM(EN), .RETURN_WIDTH(RW), .FULL_RESET_CYCLES(FRC), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .startFull(startFull), .startPartial(startPartial),
    .flushVector(flushVector), .freeListReset(freeListReset),
    .pushValid(pushValid), .pushIndex(pushIndex), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 free-list reset held, 2 returning entries
  int            mMode;
  logic [EN-1:0] mPending;
  int            mPtr;
  int            mFullLeft;
  bit            mDone;
  // scoreboard: what the current partial sequence must return vs what it did
  int            seqKind;
  logic [EN-1:0] seqFlagged;
  logic [EN-1:0] pushedSet;

  task automatic modelReset();
    mMode = 0; mPending = '0; mPtr = 0; mFullLeft = 0; mDone = 0;
    seqKind = 0; seqFlagged = '0; pushedSet = '0;
  endtask

  task automatic modelAdvance(input bit sf, input bit sp, input logic [EN-1:0] fv);
    bit newDone = 0;
    if (sf) begin
      mMode = 1; mFullLeft = FRC; mPending = '0; mPtr = 0;
      seqKind = 1; seqFlagged = '0; pushedSet = '0;
    end else if (mMode == 1) begin
      mFullLeft--;
      if (mFullLeft == 0) begin mMode = 0; newDone = 1; end
    end else if (mMode == 0) begin
      if (sp) begin
        seqKind = 2; seqFlagged = fv; pushedSet = '0;
        if (fv != '0) begin mPending = fv; mPtr = 0; mMode = 2; end
        else newDone = 1;
      end
    end else begin
      for (int i = 0; i < RW; i++) mPending[(mPtr + i) % EN] = 1'b0;
      mPtr = (mPtr + RW) % EN;
      if (sp) begin
        mPending   = mPending | fv;
        seqFlagged = seqFlagged | fv;
        pushedSet  = pushedSet & ~fv;   // re-flagged entries may return again
      end
      if (mPending == '0) begin mMode = 0; newDone = 1; end
    end
    mDone = newDone;
  endtask

  task automatic compareAll();
    logic [RW-1:0]    ePv  = '0;
    logic [RW*IW-1:0] eIdx = '0;
    int p;
    if (mMode == 2) begin
      for (int i = 0; i < RW; i++) begin
        p = (mPtr + i) % EN;
        ePv[i] = mPending[p];
        eIdx[i*IW +: IW] = p[IW-1:0];
      end
    end
    check("busy", busy, (mMode != 0));
    check("freeListReset", freeListReset, (mMode == 1));
    check("done", done, mDone);
    check("pushValid", pushValid, ePv);
    check("pushIndex", pushIndex, eIdx);
    for (int i = 0; i < RW; i++) begin
      if (pushValid[i]) begin
        logic [IW-1:0] idx;
        idx = pushIndex[i*IW +: IW];
        check("dup_push", pushedSet[idx], 1'b0);
        pushedSet[idx] = 1'b1;
      end
    end
    if (mDone) begin
      if (seqKind == 2) check("seq_coverage", pushedSet, seqFlagged);
      seqKind = 0; seqFlagged = '0; pushedSet = '0;
    end
  endtask

  // Drive inputs for one cycle, advance the model at the edge, compare after it.
  task automatic step(input bit sf, input bit sp, input logic [EN-1:0] fv);
    startFull = sf; startPartial = sp; flushVector = fv;
    @(posedge clk);
    modelAdvance(sf, sp, fv);
    #1;
    startFull = 1'b0; startPartial = 1'b0; flushVector = '0;
    compareAll();
  endtask

  int sparsePv[9] = '{1, 0, 1, 0, 0, 0, 0, 2, 0};

  initial begin
    modelReset();
    // reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_flr", freeListReset, 1'b0);
    check("rst_pv", pushValid, '0);
    check("rst_idx", pushIndex, '0);
    check("rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) step(0, 0, '0);
    check("idle_busy", busy, 1'b0);

    // full recovery: freeListReset for cycles 1..8, done at 9 only
    step(1, 0, '0);
    for (int c = 1; c <= FRC; c++) begin
      if (c > 1) step(0, 0, '0);
      check($sformatf("full_c%0d_flr", c), freeListReset, 1'b1);
      check($sformatf("full_c%0d_pv", c), pushValid, '0);
    end
    step(0, 0, '0);
    check("full_c9_done", done, 1'b1);
    check("full_c9_busy", busy, 1'b0);
    step(0, 0, '0);
    check("full_c10_done", done, 1'b0);

    // sparse partial 0x8011
    step(0, 1, 16'h8011);
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) step(0, 0, '0);
      check($sformatf("sparse_c%0d_pv", c), pushValid, sparsePv[c-1]);
      if (c == 1) check("sparse_c1_idx", pushIndex, 8'h10);
      if (c == 3) check("sparse_c3_idx", pushIndex, 8'h54);
      if (c == 8) check("sparse_c8_idx", pushIndex, 8'hFE);
    end
    check("sparse_c9_done", done, 1'b1);
    check("sparse_c9_busy", busy, 1'b0);

    // early exit and empty vector
    step(0, 1, 16'h0003);
    check("early_c1_pv", pushValid, 2'b11);
    check("early_c1_idx", pushIndex, 8'h10);
    step(0, 0, '0);
    check("early_c2_done", done, 1'b1);
    step(0, 1, 16'h0000);
    check("empty_c1_done", done, 1'b1);
    check("empty_c1_busy", busy, 1'b0);

    // nested partial: 0x00F0 at cycle 0, 0x0003 at cycle 2
    step(0, 1, 16'h00F0);
    step(0, 0, '0);
    step(0, 1, 16'h0003);
    check("nest_c3_pv", pushValid, 2'b11);
    check("nest_c3_idx", pushIndex, 8'h54);
    step(0, 0, '0);
    check("nest_c4_idx", pushIndex, 8'h76);
    repeat (5) step(0, 0, '0);
    check("nest_c9_pv", pushValid, 2'b11);
    check("nest_c9_idx", pushIndex, 8'h10);
    step(0, 0, '0);
    check("nest_c10_done", done, 1'b1);

    // full overrides an in-flight partial
    step(0, 1, 16'hFFFF);
    step(0, 0, '0);
    step(0, 0, '0);
    check("ovr_c3_idx", pushIndex, 8'h54);
    step(1, 0, '0);
    check("ovr_c4_flr", freeListReset, 1'b1);
    check("ovr_c4_pv", pushValid, '0);
    repeat (7) step(0, 0, '0);
    check("ovr_c11_flr", freeListReset, 1'b1);
    step(0, 0, '0);
    check("ovr_c12_done", done, 1'b1);

    // asynchronous reset in the middle of a return scan
    step(0, 1, 16'hFFFF);
    step(0, 0, '0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_pv", pushValid, '0);
    check("arst_idx", pushIndex, '0);
    check("arst_flr", freeListReset, 1'b0);
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, '0);
    check("arst_after_busy", busy, 1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit sf, sp;
      logic [EN-1:0] fv;
      sf = ($urandom_range(0, 39) == 0);
      sp = ($urandom_range(0, 4) == 0);
      fv = EN'($urandom) & EN'($urandom);
      if (fv == '0 && mMode != 0) fv = EN'(1) << $urandom_range(0, EN-1);
      step(sf, sp, fv);
    end
    repeat (EN) step(0, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
